// File: rtl/not16_checker_pkg.sv
// Shared definitions for the not16 inverter checker.
//   state_t    : checker FSM state encoding
//   DEF_WIDTH  : default datapath width of the checked inverter
//   DEF_CNT_W  : default width of counters and vector index
package not16_checker_pkg;

    localparam int DEF_WIDTH = 16;
    localparam int DEF_CNT_W = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/not16_cmp_stage.sv
// Registered compare stage for inverter checkers.
// Captures (a, out, idx) on valid, then presents the compare of the held
// pair against ~a combinationally for the following cycle.
//   clk, rst_n     : clock, asynchronous active-low reset
//   a, out, idx    : stimulus, response and vector index to capture
//   valid          : capture strobe (one transfer)
//   mismatch       : held response differs from ~held stimulus
//   err_mask       : held out XOR ~held a
//   cmp_a, cmp_out : held stimulus / response
//   cmp_idx        : held vector index
//   cmp_valid      : held pair is retiring this cycle
module not16_cmp_stage
    import not16_checker_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int IDX_W = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] out,
    input  logic [IDX_W-1:0] idx,
    input  logic             valid,
    output logic             mismatch,
    output logic [WIDTH-1:0] err_mask,
    output logic [WIDTH-1:0] cmp_a,
    output logic [WIDTH-1:0] cmp_out,
    output logic [IDX_W-1:0] cmp_idx,
    output logic             cmp_valid
);

    logic [WIDTH-1:0] a_p1;
    logic [WIDTH-1:0] out_p1;
    logic [IDX_W-1:0] idx_p1;
    logic             vld_p1;

    // Stage 1: hold the transferred pair
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_p1   <= '0;
            out_p1 <= '0;
            idx_p1 <= '0;
            vld_p1 <= 1'b0;
        end else begin
            vld_p1 <= valid;
            if (valid) begin
                a_p1   <= a;
                out_p1 <= out;
                idx_p1 <= idx;
            end
        end
    end

    assign err_mask  = out_p1 ^ ~a_p1;
    assign mismatch  = |err_mask;
    assign cmp_a     = a_p1;
    assign cmp_out   = out_p1;
    assign cmp_idx   = idx_p1;
    assign cmp_valid = vld_p1;

endmodule

// File: rtl/not16_checker.sv
// Self-checking responder for the 16-bit inverter datapath.
// Accepts (a, out) pairs over valid/ready, checks out == ~a, counts passes
// and fails, captures the first failing vector and reports a verdict.
//   clk, rst_n       : clock, asynchronous active-low reset
//   start, num_vec   : run request and vector count (taken in IDLE/DONE)
//   in_valid/in_ready: vector handshake; in_a stimulus, in_out response
//   busy, done, pass : run status and verdict
//   pass_cnt/fail_cnt: per-run match / mismatch counts (saturating)
//   first_fail_*     : index, stimulus and response of first mismatch
//   err_mask         : error bits of the most recently compared vector
module not16_checker
    import not16_checker_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [CNT_W-1:0] num_vec,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_out,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [CNT_W-1:0] pass_cnt,
    output logic [CNT_W-1:0] fail_cnt,
    output logic [CNT_W-1:0] first_fail_idx,
    output logic [WIDTH-1:0] first_fail_a,
    output logic [WIDTH-1:0] first_fail_out,
    output logic [WIDTH-1:0] err_mask
);

    localparam logic [CNT_W-1:0] ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + ONE;
    endfunction

    state_t           state, state_nxt;
    logic [CNT_W-1:0] num_vec_q, num_vec_nxt;
    logic [CNT_W-1:0] acc_cnt, acc_nxt;
    logic             rdy_nxt;
    logic             xfer;
    logic             start_ok;
    logic             cap_flag;

    logic             cmp_mismatch;
    logic [WIDTH-1:0] cmp_err;
    logic [WIDTH-1:0] cmp_a;
    logic [WIDTH-1:0] cmp_out;
    logic [CNT_W-1:0] cmp_idx;
    logic             cmp_valid;

    assign xfer     = in_valid && in_ready;
    assign start_ok = start && (state == IDLE || state == DONE);

    always_comb begin
        state_nxt   = state;
        num_vec_nxt = num_vec_q;
        acc_nxt     = acc_cnt;
        case (state)
            IDLE, DONE: begin
                if (start) begin
                    num_vec_nxt = num_vec;
                    acc_nxt     = '0;
                    state_nxt   = (num_vec == '0) ? DONE : RUN;
                end
            end
            RUN: begin
                if (xfer) begin
                    acc_nxt = acc_cnt + ONE;
                end
                if (acc_nxt == num_vec_q) begin
                    state_nxt = DRAIN;
                end
            end
            DRAIN: state_nxt = DONE;
            default: state_nxt = IDLE;
        endcase
        // in_ready is registered, so it is derived from the next-cycle view
        rdy_nxt = (state_nxt == RUN) && (acc_nxt < num_vec_nxt);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            num_vec_q <= '0;
            acc_cnt   <= '0;
            in_ready  <= 1'b0;
        end else begin
            state     <= state_nxt;
            num_vec_q <= num_vec_nxt;
            acc_cnt   <= acc_nxt;
            in_ready  <= rdy_nxt;
        end
    end

    assign busy = (state == RUN) || (state == DRAIN);
    assign done = (state == DONE);
    assign pass = done && (fail_cnt == '0);

    not16_cmp_stage #(
        .WIDTH (WIDTH),
        .IDX_W (CNT_W)
    ) u_cmp (
        .clk       (clk),
        .rst_n     (rst_n),
        .a         (in_a),
        .out       (in_out),
        .idx       (acc_cnt),
        .valid     (xfer),
        .mismatch  (cmp_mismatch),
        .err_mask  (cmp_err),
        .cmp_a     (cmp_a),
        .cmp_out   (cmp_out),
        .cmp_idx   (cmp_idx),
        .cmp_valid (cmp_valid)
    );

    // Stage 2: retire the compare into counters and first-fail capture
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pass_cnt       <= '0;
            fail_cnt       <= '0;
            cap_flag       <= 1'b0;
            first_fail_idx <= '0;
            first_fail_a   <= '0;
            first_fail_out <= '0;
            err_mask       <= '0;
        end else if (start_ok) begin
            pass_cnt       <= '0;
            fail_cnt       <= '0;
            cap_flag       <= 1'b0;
            first_fail_idx <= '0;
            first_fail_a   <= '0;
            first_fail_out <= '0;
        end else if (cmp_valid) begin
            err_mask <= cmp_err;
            if (cmp_mismatch) begin
                fail_cnt <= sat_inc(fail_cnt);
                if (!cap_flag) begin
                    cap_flag       <= 1'b1;
                    first_fail_idx <= cmp_idx;
                    first_fail_a   <= cmp_a;
                    first_fail_out <= cmp_out;
                end
            end else begin
                pass_cnt <= sat_inc(pass_cnt);
            end
        end
    end

endmodule

// File: tb/tb_not16_checker.sv
// Directed-vector bench for not16_checker: reset values, clean run,
// injected faults, bubbles/ignored inputs, zero-length run and restart,
// asynchronous reset mid-run.
module tb_not16_checker;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [15:0] num_vec;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_a;
    logic [15:0] in_out;
    logic        busy;
    logic        done;
    logic        pass;
    logic [15:0] pass_cnt;
    logic [15:0] fail_cnt;
    logic [15:0] first_fail_idx;
    logic [15:0] first_fail_a;
    logic [15:0] first_fail_out;
    logic [15:0] err_mask;

    int n_chk  = 0;
    int n_pass = 0;

    not16_checker dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .start          (start),
        .num_vec        (num_vec),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .in_a           (in_a),
        .in_out         (in_out),
        .busy           (busy),
        .done           (done),
        .pass           (pass),
        .pass_cnt       (pass_cnt),
        .fail_cnt       (fail_cnt),
        .first_fail_idx (first_fail_idx),
        .first_fail_a   (first_fail_a),
        .first_fail_out (first_fail_out),
        .err_mask       (err_mask)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp)
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        else
            n_pass++;
    endtask

    // advance to just after the next rising edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [15:0] a, input logic [15:0] o);
        int w;
        in_valid = 1'b1;
        in_a     = a;
        in_out   = o;
        w = 0;
        while (!in_ready && w < 20) begin
            step();
            w++;
        end
        if (w >= 20) check("rdy_timeout", in_ready, 1);
        step();
    endtask

    task automatic do_start(input logic [15:0] n);
        start   = 1'b1;
        num_vec = n;
        step();
        start   = 1'b0;
    endtask

    logic [15:0] clean_a [7] = '{16'h0000, 16'h0001, 16'h0002, 16'h0003,
                                 16'hFFFF, 16'hAAAA, 16'h5555};

    initial begin
        logic [5:0] pat;
        logic       prev_done;
        int         rises;

        // ---------------- reset values ----------------
        rst_n = 1'b0;
        for (int i = 0; i < 4; i++) begin
            start    = 1'($urandom);
            num_vec  = 16'($urandom);
            in_valid = 1'($urandom);
            in_a     = 16'($urandom);
            in_out   = 16'($urandom);
            step();
        end
        check("rst_in_ready", in_ready, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_pass", pass, 0);
        check("rst_pass_cnt", pass_cnt, 0);
        check("rst_fail_cnt", fail_cnt, 0);
        check("rst_ff_idx", first_fail_idx, 0);
        check("rst_ff_a", first_fail_a, 0);
        check("rst_ff_out", first_fail_out, 0);
        check("rst_err_mask", err_mask, 0);
        start = 1'b0; in_valid = 1'b0; num_vec = '0; in_a = '0; in_out = '0;
        #3 rst_n = 1'b1;
        step(); step(); step();
        check("idle_busy", busy, 0);
        check("idle_done", done, 0);
        check("idle_ready", in_ready, 0);

        // ---------------- clean run ----------------
        do_start(16'd7);
        check("clean_busy", busy, 1);
        check("clean_ready", in_ready, 1);
        for (int i = 0; i < 7; i++) begin
            send(clean_a[i], ~clean_a[i]);
            if (i == 0) check("clean_lat0", pass_cnt, 0);
            if (i == 1) check("clean_lat1", pass_cnt, 1);
        end
        in_valid = 1'b0;
        check("clean_ready_low", in_ready, 0);
        check("clean_not_done", done, 0);
        step();
        step();
        check("clean_done", done, 1);
        check("clean_pass", pass, 1);
        check("clean_pass_cnt", pass_cnt, 7);
        check("clean_fail_cnt", fail_cnt, 0);
        check("clean_busy_end", busy, 0);

        // ---------------- injected faults ----------------
        do_start(16'd4);
        check("flt_cleared", pass_cnt, 0);
        check("flt_done_drop", done, 0);
        send(16'h0000, 16'hFFFF);
        send(16'h0001, 16'hFFFE);
        send(16'h0002, 16'hFFFF);
        send(16'h0003, 16'h0000);
        in_valid = 1'b0;
        step(); step();
        check("flt_fail_cnt", fail_cnt, 2);
        check("flt_pass_cnt", pass_cnt, 2);
        check("flt_ff_idx", first_fail_idx, 2);
        check("flt_ff_a", first_fail_a, 16'h0002);
        check("flt_ff_out", first_fail_out, 16'hFFFF);
        check("flt_err_mask", err_mask, 16'hFFFC);
        check("flt_done", done, 1);
        check("flt_pass", pass, 0);

        // ---------------- bubbles and ignored inputs ----------------
        do_start(16'd3);
        pat = 6'b101001;
        prev_done = done;
        rises = 0;
        for (int i = 0; i < 6; i++) begin
            in_valid = pat[i];
            in_a     = 16'h1000 + 16'(i);
            in_out   = ~(16'h1000 + 16'(i));
            start    = (i == 2);
            num_vec  = 16'd9;
            step();
            if (done && !prev_done) rises++;
            prev_done = done;
            if (i == 2) check("bub_start_ignored", busy, 1);
        end
        start    = 1'b0;
        // held valid with a bad pair while not ready must be ignored
        in_valid = 1'b1;
        in_a     = 16'h0F0F;
        in_out   = 16'h0F0F;
        for (int i = 0; i < 5; i++) begin
            step();
            if (done && !prev_done) rises++;
            prev_done = done;
        end
        in_valid = 1'b0;
        check("bub_pass_cnt", pass_cnt, 3);
        check("bub_fail_cnt", fail_cnt, 0);
        check("bub_done_once", rises, 1);
        check("bub_pass", pass, 1);

        // ---------------- zero length and restart ----------------
        do_start(16'd0);
        check("zero_done", done, 1);
        check("zero_pass", pass, 1);
        check("zero_pass_cnt", pass_cnt, 0);
        check("zero_fail_cnt", fail_cnt, 0);
        do_start(16'd1);
        check("rs_done_drop", done, 0);
        check("rs_busy", busy, 1);
        send(16'h1234, 16'h1234);
        in_valid = 1'b0;
        step(); step();
        check("rs_fail_cnt", fail_cnt, 1);
        check("rs_pass_cnt", pass_cnt, 0);
        check("rs_pass", pass, 0);
        check("rs_done", done, 1);
        check("rs_ff_idx", first_fail_idx, 0);
        check("rs_err_mask", err_mask, 16'hFFFF);

        // ---------------- async reset mid-run ----------------
        do_start(16'd5);
        send(16'h0010, ~16'h0010);
        send(16'h0011, ~16'h0011);
        in_valid = 1'b0;
        check("ar_busy_pre", busy, 1);
        check("ar_pass_cnt_pre", pass_cnt, 1);
        #2 rst_n = 1'b0;
        #1;
        check("ar_busy", busy, 0);
        check("ar_ready", in_ready, 0);
        check("ar_pass_cnt", pass_cnt, 0);
        check("ar_err_mask", err_mask, 0);
        check("ar_done", done, 0);
        #3 rst_n = 1'b1;
        step(); step();
        check("ar_idle_busy", busy, 0);
        check("ar_idle_ready", in_ready, 0);
        check("ar_idle_pass_cnt", pass_cnt, 0);
        check("ar_idle_done", done, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
